// File: rtl/idu_arbiter_if.sv
// idu_arbiter_if: bundle of requester, idu and response signals around the idu arbiter.
//   master : requester/idu side (drives hold, req*, idu_data_out; reads grant and response)
//   slave  : arbiter side (drives gnt, idu_data_in, idu_mode, rsp_*)
//   hold          pipeline stall, no grants while high
//   req/req_lock  per-requester request and ownership-lock
//   req_mode      per-requester idu mode (1 = inc, 0 = dec)
//   req_data      flattened operands, slice i = req_data[i*DW +: DW]
//   gnt           one-hot grant
//   idu_data_in/idu_mode/idu_data_out  connection to the shared idu
//   rsp_valid/rsp_id/rsp_data          registered result tagged with requester id
interface idu_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic                 hold;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ-1:0]      req_mode;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic [DW-1:0]        idu_data_in;
    logic                 idu_mode;
    logic [DW-1:0]        idu_data_out;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [DW-1:0]        rsp_data;

    modport master (
        output hold, req, req_lock, req_mode, req_data, idu_data_out,
        input  gnt, idu_data_in, idu_mode, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  hold, req, req_lock, req_mode, req_data, idu_data_out,
        output gnt, idu_data_in, idu_mode, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/idu_arbiter.sv
// idu_arbiter: shares one 16-bit increment/decrement unit between PC, SP, HL and DMA.
// Round-robin arbitration with an optional per-grant lock that keeps ownership while the
// locked requester keeps req high. The winner is muxed onto the idu inputs; the idu result is
// registered and returned one cycle later tagged with the requester id.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    idu_arbiter_if.slave (requests, grant, idu connection, response)
module idu_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    idu_arbiter_if.slave   bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] lock_id;
    logic           lock_vld;
    logic [IDW-1:0] gnt_id;
    logic           gnt_any;

    // Lock has priority only while its owner still requests; otherwise fall through to
    // a round-robin search starting at rr_ptr.
    always_comb begin
        logic [IDW-1:0] cand;
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (!bus.hold) begin
            if (lock_vld && bus.req[lock_id]) begin
                gnt_any = 1'b1;
                gnt_id  = lock_id;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    cand = IDW'((int'(rr_ptr) + k) % NREQ);
                    if (!gnt_any && bus.req[cand]) begin
                        gnt_any = 1'b1;
                        gnt_id  = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.gnt         = '0;
        bus.idu_data_in = '0;
        bus.idu_mode    = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_any && (gnt_id == IDW'(i))) begin
                bus.gnt[i]      = 1'b1;
                bus.idu_data_in = bus.req_data[i*DW +: DW];
                bus.idu_mode    = bus.req_mode[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            lock_vld      <= 1'b0;
            lock_id       <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
        end else if (gnt_any) begin
            rr_ptr        <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
            lock_vld      <= bus.req_lock[gnt_id];
            lock_id       <= gnt_id;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= gnt_id;
            bus.rsp_data  <= bus.idu_data_out;
        end else begin
            bus.rsp_valid <= 1'b0;
            // hold alone never drops the lock; only the owner withdrawing its request does
            if (lock_vld && !bus.req[lock_id]) begin
                lock_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_idu_arbiter.sv
// tb_idu_arbiter: directed vector table, hand-written reset sequences and a randomized run
// against a behavioural model of the arbiter plus an ideal idu.
module tb_idu_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 16;

    logic clk;
    logic rst_n;

    idu_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

    idu_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ideal idu: wraps modulo 2^16
    assign bus.idu_data_out = bus.idu_mode ? bus.idu_data_in + 16'd1 : bus.idu_data_in - 16'd1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    logic [15:0] dat [4];

    task automatic apply(input logic h, input logic [3:0] r, input logic [3:0] lk,
                         input logic [3:0] md, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3);
        bus.hold     = h;
        bus.req      = r;
        bus.req_lock = lk;
        bus.req_mode = md;
        dat[0] = d0; dat[1] = d1; dat[2] = d2; dat[3] = d3;
        bus.req_data = {d3, d2, d1, d0};
    endtask

    typedef struct {
        logic        hold;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [3:0]  mode;
        logic [15:0] d0, d1, d2, d3;
        logic [3:0]  gnt;
        logic        rv;
        logic [1:0]  rid;
        logic [15:0] rdata;
    } vec_t;

    vec_t vt [18];

    // behavioural model state
    int          m_ptr;
    int          m_owner;   // -1 = no lock
    logic        m_rv;
    int          m_rid;
    logic [15:0] m_rdata;

    function automatic int model_pick(input logic h, input logic [3:0] r);
        if (h) return -1;
        if (m_owner >= 0 && ((r >> m_owner) & 4'd1) != 0) return m_owner;
        for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (((r >> j) & 4'd1) != 0) return j;
        end
        return -1;
    endfunction

    function automatic logic [15:0] idu_ref(input logic [15:0] d, input logic m);
        int v;
        v = m ? (int'(d) + 1) % 65536 : (int'(d) + 65535) % 65536;
        return v[15:0];
    endfunction

    initial begin
        vt[0]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 16'h0000, 16'h0000, 16'h0011, 16'h0000, 4'b0100, 1'b1, 2'd2, 16'h0012};
        vt[1]  = '{1'b0, 4'b0100, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 16'h0011, 16'h0000, 4'b0100, 1'b1, 2'd2, 16'h0010};
        vt[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 16'h0000, 16'h0011, 16'h0000, 4'b0000, 1'b0, 2'd2, 16'h0010};
        vt[3]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 16'h1000, 16'h1010, 16'h1020, 16'h1030, 4'b1000, 1'b1, 2'd3, 16'h1031};
        vt[4]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 16'h1000, 16'h1010, 16'h1020, 16'h1030, 4'b0001, 1'b1, 2'd0, 16'h1001};
        vt[5]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 16'h1000, 16'h1010, 16'h1020, 16'h1030, 4'b0010, 1'b1, 2'd1, 16'h1011};
        vt[6]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 16'h1000, 16'h1010, 16'h1020, 16'h1030, 4'b0100, 1'b1, 2'd2, 16'h1021};
        vt[7]  = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 16'h1000, 16'h1010, 16'h1020, 16'h1030, 4'b1000, 1'b1, 2'd3, 16'h1031};
        vt[8]  = '{1'b0, 4'b0000, 4'b0000, 4'b1111, 16'h1000, 16'h1010, 16'h1020, 16'h1030, 4'b0000, 1'b0, 2'd3, 16'h1031};
        vt[9]  = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 16'h0100, 16'hFFFE, 16'h0000, 16'h0000, 4'b0010, 1'b1, 2'd1, 16'hFFFD};
        vt[10] = '{1'b0, 4'b0011, 4'b0010, 4'b0001, 16'h0100, 16'hFFFD, 16'h0000, 16'h0000, 4'b0010, 1'b1, 2'd1, 16'hFFFC};
        vt[11] = '{1'b0, 4'b0001, 4'b0010, 4'b0001, 16'h0100, 16'hFFFD, 16'h0000, 16'h0000, 4'b0001, 1'b1, 2'd0, 16'h0101};
        vt[12] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b1, 2'd0, 16'h0000};
        vt[13] = '{1'b0, 4'b0010, 4'b0010, 4'b0000, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 4'b0010, 1'b1, 2'd1, 16'h0004};
        vt[14] = '{1'b1, 4'b0011, 4'b0010, 4'b0001, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 4'b0000, 1'b0, 2'd1, 16'h0004};
        vt[15] = '{1'b1, 4'b0011, 4'b0010, 4'b0001, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 4'b0000, 1'b0, 2'd1, 16'h0004};
        vt[16] = '{1'b0, 4'b0011, 4'b0010, 4'b0001, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 4'b0010, 1'b1, 2'd1, 16'h0004};
        vt[17] = '{1'b0, 4'b0000, 4'b0000, 4'b0001, 16'hFFFF, 16'h0005, 16'h0000, 16'h0000, 4'b0000, 1'b0, 2'd1, 16'h0004};

        // reset with all requests high
        rst_n = 1'b0;
        apply(1'b0, 4'hF, 4'h0, 4'hF, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #2;
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_id",    32'(bus.rsp_id),    32'd0);
        check("reset rsp_data",  32'(bus.rsp_data),  32'd0);
        check("reset gnt",       32'(bus.gnt),       32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("first grant rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("first grant rsp_id",    32'(bus.rsp_id),    32'd0);
        check("first grant rsp_data",  32'(bus.rsp_data),  32'h0001);

        for (int i = 0; i < 18; i++) begin
            apply(vt[i].hold, vt[i].req, vt[i].lock, vt[i].mode, vt[i].d0, vt[i].d1, vt[i].d2, vt[i].d3);
            #2;
            check($sformatf("vec%0d gnt", i), 32'(bus.gnt), 32'(vt[i].gnt));
            @(posedge clk); #1;
            check($sformatf("vec%0d rsp_valid", i), 32'(bus.rsp_valid), 32'(vt[i].rv));
            check($sformatf("vec%0d rsp_id", i),    32'(bus.rsp_id),    32'(vt[i].rid));
            check($sformatf("vec%0d rsp_data", i),  32'(bus.rsp_data),  32'(vt[i].rdata));
        end

        // async reset while a lock is held and a response is pending
        apply(1'b0, 4'b0010, 4'b0010, 4'b0000, 16'h0042, 16'h0005, 16'h0000, 16'h0000);
        @(posedge clk); #1;
        check("pre-reset rsp_valid", 32'(bus.rsp_valid), 32'd1);
        apply(1'b0, 4'b0011, 4'b0010, 4'b0000, 16'h0042, 16'h0005, 16'h0000, 16'h0000);
        #2;
        check("pre-reset locked gnt", 32'(bus.gnt), 32'b0010);
        rst_n = 1'b0;
        #1;
        check("mid reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid reset rsp_id",    32'(bus.rsp_id),    32'd0);
        check("mid reset rsp_data",  32'(bus.rsp_data),  32'd0);
        check("mid reset gnt",       32'(bus.gnt),       32'b0001);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(1'b0, 4'b0011, 4'b0000, 4'b0001, 16'h0042, 16'h0005, 16'h0000, 16'h0000);
        #2;
        check("post reset gnt", 32'(bus.gnt), 32'b0001);
        @(posedge clk); #1;
        check("post reset rsp_id",   32'(bus.rsp_id),   32'd0);
        check("post reset rsp_data", 32'(bus.rsp_data), 32'h0043);

        // randomized run against the model
        rst_n = 1'b0;
        apply(1'b0, 4'h0, 4'h0, 4'h0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        #2;
        rst_n = 1'b1;
        m_ptr = 0; m_owner = -1; m_rv = 1'b0; m_rid = 0; m_rdata = 16'h0000;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [15:0] rd [4];
            int g;
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 5))
                    0:       rd[i] = 16'hFFFF;
                    1:       rd[i] = 16'h0000;
                    default: rd[i] = 16'($urandom);
                endcase
            end
            apply($urandom_range(0, 6) == 0, 4'($urandom), 4'($urandom), 4'($urandom),
                  rd[0], rd[1], rd[2], rd[3]);
            #2;
            g = model_pick(bus.hold, bus.req);
            if (g >= 0) begin
                check($sformatf("rnd%0d gnt", cyc), 32'(bus.gnt), 32'(1) << g);
                check($sformatf("rnd%0d idu_data_in", cyc), 32'(bus.idu_data_in), 32'(dat[g]));
                check($sformatf("rnd%0d idu_mode", cyc), 32'(bus.idu_mode), 32'(bus.req_mode[g]));
            end else begin
                check($sformatf("rnd%0d gnt", cyc), 32'(bus.gnt), 32'd0);
                check($sformatf("rnd%0d idu_data_in", cyc), 32'(bus.idu_data_in), 32'd0);
                check($sformatf("rnd%0d idu_mode", cyc), 32'(bus.idu_mode), 32'd1);
            end
            if (g >= 0) begin
                m_rv    = 1'b1;
                m_rid   = g;
                m_rdata = idu_ref(dat[g], bus.req_mode[g]);
                m_ptr   = (g + 1) % 4;
                m_owner = bus.req_lock[g] ? g : -1;
            end else begin
                m_rv = 1'b0;
                if (m_owner >= 0 && !bus.req[m_owner]) m_owner = -1;
            end
            @(posedge clk); #1;
            check($sformatf("rnd%0d rsp_valid", cyc), 32'(bus.rsp_valid), 32'(m_rv));
            check($sformatf("rnd%0d rsp_id", cyc),    32'(bus.rsp_id),    32'(m_rid));
            check($sformatf("rnd%0d rsp_data", cyc),  32'(bus.rsp_data),  32'(m_rdata));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
